// File: rtl/spi_buffer_pkg.sv
// Shared attribute layout and width helpers for the SPI buffer and the SPI slave.
package spi_buffer_pkg;

  localparam int ATTR_WIDTH = 4;

  localparam int INVALID    = 0;
  localparam int VALID      = 1;
  localparam int SPI_FINISH = 2;
  localparam int FULL       = 3;

  // Pointer addresses 0..size-1; a count must also represent the value size itself.
  function automatic int ptr_width(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/spi_ring_ptr.sv
// Modulo-SIZE pointer with increment enable and synchronous clear.
module spi_ring_ptr
  import spi_buffer_pkg::*;
#(
  parameter int SIZE = 10,
  parameter int W    = ptr_width(SIZE)
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == W'(SIZE - 1)) ? '0 : ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i || clear_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/spi_ring_buffer.sv
// Circular word buffer between the SPI slave shifter and the processor-unit bus.
// Optional build macro SPI_RING_BUFFER_OVERWRITE_EN: writes to a full buffer replace the oldest word.
module spi_ring_buffer
  import spi_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_SIZE   = 10,
  parameter int ATTR_WIDTH = spi_buffer_pkg::ATTR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          wr,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          frame_end,
  input  logic                          oe,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [cnt_width(BUF_SIZE)-1:0] count,
  output logic                          overflow,
  output logic [ATTR_WIDTH-1:0]         attr_out
);

  localparam int PTR_W = ptr_width(BUF_SIZE);
  localparam int CNT_W = cnt_width(BUF_SIZE);
  localparam logic [ATTR_WIDTH-1:0] ATTR_RST = ATTR_WIDTH'(1) << INVALID;

  logic [DATA_WIDTH-1:0] mem [BUF_SIZE];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  pending_q, pending_d;
  logic                  finish_q, finish_d;
  logic [ATTR_WIDTH-1:0] attr_q, attr_d;

  logic full;
  logic rd_acc;
  logic wr_acc;
  logic pop;

  assign full   = (count_q == CNT_W'(BUF_SIZE));
  assign rd_acc = oe && (count_q != '0);

`ifdef SPI_RING_BUFFER_OVERWRITE_EN
  // A write into a full buffer always lands; the head is dropped to make room.
  assign wr_acc = wr;
  assign pop    = rd_acc || (wr && full);
`else
  assign wr_acc = wr && (!full || rd_acc);
  assign pop    = rd_acc;
`endif

  spi_ring_ptr #(.SIZE(BUF_SIZE), .W(PTR_W)) u_wr_ptr (
    .clk     (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .inc_i   (wr_acc),
    .ptr_o   (wr_ptr)
  );

  spi_ring_ptr #(.SIZE(BUF_SIZE), .W(PTR_W)) u_rd_ptr (
    .clk     (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .inc_i   (pop),
    .ptr_o   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q | (wr && full && !rd_acc);
    pending_d  = pending_q | frame_end;
    finish_d   = finish_q;
    attr_d     = '0;

    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A closed frame is reported once every word it delivered has been read out.
    if (wr_acc) begin
      finish_d = 1'b0;
    end else if (pending_d && (count_d == '0)) begin
      finish_d  = 1'b1;
      pending_d = 1'b0;
    end

    attr_d[INVALID]    = (count_d == '0);
    attr_d[VALID]      = (count_d != '0);
    attr_d[SPI_FINISH] = finish_d;
    attr_d[FULL]       = (count_d == CNT_W'(BUF_SIZE));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
      finish_q   <= 1'b0;
      attr_q     <= ATTR_RST;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      finish_q   <= finish_d;
      attr_q     <= attr_d;
    end
  end

  assign data_out = (oe && !attr_q[INVALID]) ? mem[rd_ptr] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign attr_out = attr_q;

endmodule

// File: tb/tb_spi_ring_buffer.sv
// Directed plus randomized bench for spi_ring_buffer against a queue-based reference model.
module tb_spi_ring_buffer;
  import spi_buffer_pkg::*;

  localparam int DW = 32;
  localparam int BS = 10;
  localparam int AW = 4;
  localparam int CW = $clog2(BS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          frame_end = 1'b0;
  logic          oe = 1'b0;
  logic [DW-1:0] data_out;
  logic [CW-1:0] count;
  logic          overflow;
  logic [AW-1:0] attr_out;

  // Reference state: stored words in arrival order plus status flags.
  logic [DW-1:0] exp_q[$];
  bit            exp_ovf;
  bit            exp_pend;
  bit            exp_fin;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  spi_ring_buffer #(.DATA_WIDTH(DW), .BUF_SIZE(BS), .ATTR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .wr        (wr),
    .data_in   (data_in),
    .frame_end (frame_end),
    .oe        (oe),
    .data_out  (data_out),
    .count     (count),
    .overflow  (overflow),
    .attr_out  (attr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_attr();
    logic [AW-1:0] a;
    a             = '0;
    a[INVALID]    = (exp_q.size() == 0);
    a[VALID]      = (exp_q.size() != 0);
    a[SPI_FINISH] = exp_fin;
    a[FULL]       = (exp_q.size() == BS);
    return a;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_pend = 1'b0;
    exp_fin  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    check({tag, ".attr"}, 64'(attr_out), 64'(exp_attr()));
    check({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf));
  endtask

  // One clock of stimulus: inputs applied at the falling edge, outputs checked around the rising edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit o, input bit fe, input bit clr);
    bit rd_ok;
    bit wr_ok;
    wr        = w;
    data_in   = d;
    oe        = o;
    frame_end = fe;
    clear     = clr;
    #1;
    check("data_out", 64'(data_out), (o && exp_q.size() != 0) ? 64'(exp_q[0]) : 64'(0));
    if (clr) begin
      model_reset();
    end else begin
      rd_ok = o && (exp_q.size() != 0);
      wr_ok = 1'b0;
      if (w && exp_q.size() == BS && !rd_ok) exp_ovf = 1'b1;
      if (rd_ok) void'(exp_q.pop_front());
      if (w) begin
        if (exp_q.size() < BS) begin
          exp_q.push_back(d);
          wr_ok = 1'b1;
        end else begin
`ifdef SPI_RING_BUFFER_OVERWRITE_EN
          void'(exp_q.pop_front());
          exp_q.push_back(d);
          wr_ok = 1'b1;
`endif
        end
      end
      if (fe) exp_pend = 1'b1;
      if (wr_ok) begin
        exp_fin = 1'b0;
      end else if (exp_pend && exp_q.size() == 0) begin
        exp_fin  = 1'b1;
        exp_pend = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_status("step");
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    wr        = 1'b0;
    oe        = 1'b0;
    clear     = 1'b0;
    frame_end = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, checked against literal values.
    do_reset();
    check("reset.attr", 64'(attr_out), 64'h1);
    check("reset.count", 64'(count), 64'h0);
    check("reset.overflow", 64'(overflow), 64'h0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Fill, overfill, drain in order.
    for (int i = 1; i <= 10; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    check("fill.count", 64'(count), 64'd10);
    check("fill.full", 64'(attr_out[FULL]), 64'h1);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    check("overfill.overflow", 64'(overflow), 64'h1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Wrap across the last index.
    for (int i = 0; i < 7; i++) step(1'b1, 32'h10 + DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 32'h20 + DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Simultaneous write and read while full, then while empty.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h30 + DW'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    check("full_rw.count", 64'(count), 64'd10);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    check("empty_rw.count", 64'(count), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Frame completion flag.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + DW'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("finish.before_last", 64'(attr_out[SPI_FINISH]), 64'h0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("finish.after_last", 64'(attr_out[SPI_FINISH]), 64'h1);
    step(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
    check("finish.cleared_by_write", 64'(attr_out[SPI_FINISH]), 64'h0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("finish.empty_frame", 64'(attr_out[SPI_FINISH]), 64'h1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Clear with traffic in flight.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h60 + DW'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h66, 1'b1, 1'b0, 1'b1);
    check("clear.attr", 64'(attr_out), 64'h1);
    check("clear.count", 64'(count), 64'h0);

    // Write into a full buffer, result depends on the overwrite build option.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h80 + DW'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional frame ends and clears.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
      if (n == 300) begin
        do_reset();
        check_status("mid_reset");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
